// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter that merges N_SRCS writeback sources onto a single
// register-file write port with one registered cycle of latency.
module rf_wr_arbiter #(
   parameter int ENTRY_WIDTH = 32,
   parameter int N_ENTRIES   = 32,
   parameter int N_SRCS      = 4,
   localparam int PTR_WIDTH  = $clog2(N_ENTRIES)
) (
   input  logic                                  clk,
   input  logic                                  rst_aH,
   input  logic                                  flush,
   input  logic [N_SRCS-1:0]                     src_valid,
   input  logic [N_SRCS-1:0][PTR_WIDTH-1:0]      src_addr,
   input  logic [N_SRCS-1:0][ENTRY_WIDTH-1:0]    src_data,
   output logic [N_SRCS-1:0]                     src_ready,
   output logic                                  wr_en,
   output logic [PTR_WIDTH-1:0]                  wr_addr,
   output logic [ENTRY_WIDTH-1:0]                wr_data
);

   localparam int SEL_WIDTH = $clog2(N_SRCS);

   logic [SEL_WIDTH-1:0]   rr_ptr;
   logic [SEL_WIDTH-1:0]   grant_idx;
   logic [SEL_WIDTH-1:0]   next_ptr;
   logic                   grant_found;
   logic                   transfer;
   logic [PTR_WIDTH-1:0]   grant_addr;
   logic [ENTRY_WIDTH-1:0] grant_data;

   // Scan sources starting at rr_ptr and wrapping; the first valid one wins.
   always_comb begin
      int cand;
      cand        = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 0; k < N_SRCS; k++) begin
         cand = (int'(rr_ptr) + k) % N_SRCS;
         if (!grant_found && src_valid[cand]) begin
            grant_found = 1'b1;
            grant_idx   = SEL_WIDTH'(cand);
         end
      end
   end

   // Flush and reset both suppress the grant so nothing is consumed.
   always_comb begin
      src_ready = '0;
      if (grant_found && !flush && !rst_aH)
         src_ready[grant_idx] = 1'b1;
   end

   assign transfer   = |src_ready;
   assign grant_addr = src_addr[grant_idx];
   assign grant_data = src_data[grant_idx];
   assign next_ptr   = (int'(grant_idx) == N_SRCS - 1) ? '0 : grant_idx + SEL_WIDTH'(1);

   // Address 0 is a hardwired zero register, so such writes are consumed but dropped.
   always_ff @(posedge clk or posedge rst_aH) begin
      if (rst_aH) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         rr_ptr  <= '0;
      end else begin
         wr_en <= 1'b0;
         if (flush) begin
            rr_ptr <= '0;
         end else if (transfer) begin
            wr_en   <= (grant_addr != '0);
            wr_addr <= grant_addr;
            wr_data <= grant_data;
            rr_ptr  <= next_ptr;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst_aH) begin
         assert ($onehot0(src_ready))
            else $error("src_ready not one-hot: %b", src_ready);
         assert ((src_ready & ~src_valid) == '0)
            else $error("src_ready without src_valid: ready=%b valid=%b", src_ready, src_valid);
      end
   end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed plus randomized bench for rf_wr_arbiter; a small round-robin model
// predicts grants and pushes the expected write-port values onto a scoreboard.
module tb_rf_wr_arbiter;

   typedef struct packed {
      logic        en;
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic             clk;
   logic             rst_aH;
   logic             flush;
   logic [3:0]       src_valid;
   logic [3:0][4:0]  src_addr;
   logic [3:0][31:0] src_data;
   logic [3:0]       src_ready;
   logic             wr_en;
   logic [4:0]       wr_addr;
   logic [31:0]      wr_data;

   exp_t  expQ[$];
   int    modelPtr;
   logic [4:0]  holdAddr;
   logic [31:0] holdData;
   int    checkCount;
   int    passCount;

   rf_wr_arbiter #(.ENTRY_WIDTH(32), .N_ENTRIES(32), .N_SRCS(4)) dut (
      .clk       (clk),
      .rst_aH    (rst_aH),
      .flush     (flush),
      .src_valid (src_valid),
      .src_addr  (src_addr),
      .src_data  (src_data),
      .src_ready (src_ready),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
   endtask

   function automatic int modelGrant(input logic [3:0] v, input int ptr);
      for (int k = 0; k < 4; k++) begin
         if (v[(ptr + k) % 4]) return (ptr + k) % 4;
      end
      return -1;
   endfunction

   task automatic modelReset();
      modelPtr = 0;
      holdAddr = '0;
      holdData = '0;
      expQ.delete();
   endtask

   // Drive one cycle: check the grant mid-cycle, then the write port after the edge.
   task automatic applyStimulus(input logic [3:0] v, input logic f, output int g);
      exp_t e;
      src_valid = v;
      flush     = f;
      @(negedge clk);
      g = f ? -1 : modelGrant(v, modelPtr);
      checkOutput("src_ready", 64'(src_ready), (g >= 0) ? 64'(4'b0001 << g) : 64'd0);
      if (f) begin
         modelPtr = 0;
         e = '{en: 1'b0, addr: holdAddr, data: holdData};
      end else if (g >= 0) begin
         holdAddr = src_addr[g];
         holdData = src_data[g];
         modelPtr = (g + 1) % 4;
         e = '{en: (holdAddr != 5'd0), addr: holdAddr, data: holdData};
      end else begin
         e = '{en: 1'b0, addr: holdAddr, data: holdData};
      end
      expQ.push_back(e);
      @(posedge clk);
      #1;
      e = expQ.pop_front();
      checkOutput("wr_en", 64'(wr_en), 64'(e.en));
      checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
      checkOutput("wr_data", 64'(wr_data), 64'(e.data));
      checkOutput("rr_ptr", 64'(dut.rr_ptr), 64'(modelPtr));
   endtask

   initial begin
      int g;
      int wait2;
      checkCount = 0;
      passCount  = 0;
      modelReset();
      rst_aH    = 1'b1;
      flush     = 1'b0;
      src_valid = 4'b0000;
      src_addr  = '0;
      src_data  = '0;

      // Reset state, sampled before any clock edge
      #2;
      src_valid = 4'b1111;
      #1;
      checkOutput("reset_wr_en", 64'(wr_en), 64'd0);
      checkOutput("reset_wr_addr", 64'(wr_addr), 64'd0);
      checkOutput("reset_wr_data", 64'(wr_data), 64'd0);
      checkOutput("reset_rr_ptr", 64'(dut.rr_ptr), 64'd0);
      checkOutput("reset_src_ready", 64'(src_ready), 64'd0);
      src_valid = 4'b0000;
      @(negedge clk);
      rst_aH = 1'b0;
      @(posedge clk);
      #1;

      // All four sources requesting: grants rotate 0,1,2,3
      $display("[TB] all-valid rotation");
      for (int i = 0; i < 4; i++) begin
         src_addr[i] = 5'(i + 1);
         src_data[i] = 32'hA000_0000 + 32'(i);
      end
      for (int i = 0; i < 4; i++) begin
         applyStimulus(4'b1111, 1'b0, g);
         checkOutput("rotation_order", 64'(g), 64'(i));
      end

      // Move pointer to 2, then wrap to lower sources
      $display("[TB] wrap-around from pointer 2");
      applyStimulus(4'b0010, 1'b0, g);
      applyStimulus(4'b0011, 1'b0, g);
      checkOutput("wrap_grant0", 64'(g), 64'd0);
      applyStimulus(4'b0011, 1'b0, g);
      checkOutput("wrap_grant1", 64'(g), 64'd1);

      // Write to address 0 is consumed without a write
      $display("[TB] address-zero write");
      src_addr[1] = 5'd0;
      src_data[1] = 32'hDEADBEEF;
      applyStimulus(4'b0010, 1'b0, g);
      checkOutput("addr0_ptr", 64'(dut.rr_ptr), 64'd2);

      // Flush blocks the grant and clears the pointer
      $display("[TB] flush");
      src_addr[3] = 5'd19;
      src_data[3] = 32'h3333_0003;
      applyStimulus(4'b1000, 1'b1, g);
      applyStimulus(4'b1000, 1'b0, g);
      checkOutput("post_flush_grant", 64'(g), 64'd3);

      // Idle cycle holds address and data
      applyStimulus(4'b0000, 1'b0, g);

      // Source 2 held valid while others toggle randomly
      $display("[TB] fairness for source 2");
      wait2 = 0;
      src_addr[2] = 5'd22;
      src_data[2] = 32'h2222_0000;
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (i != 2) begin
               src_addr[i] = 5'($urandom_range(0, 31));
               src_data[i] = $urandom;
            end
         end
         applyStimulus(4'($urandom_range(0, 15)) | 4'b0100, 1'b0, g);
         if (g == 2) begin
            checkOutput("src2_wait_bound", 64'(wait2 < 4), 64'd1);
            wait2 = 0;
            src_addr[2] = 5'($urandom_range(1, 31));
            src_data[2] = $urandom;
         end else begin
            wait2++;
         end
      end
      checkOutput("src2_final_wait", 64'(wait2 < 4), 64'd1);

      // Asynchronous reset mid-cycle during an active transfer
      $display("[TB] asynchronous reset");
      src_addr[0] = 5'd7;
      src_data[0] = 32'h5555_AAAA;
      applyStimulus(4'b0001, 1'b0, g);
      #1;
      rst_aH = 1'b1;
      #1;
      checkOutput("async_wr_en", 64'(wr_en), 64'd0);
      checkOutput("async_wr_addr", 64'(wr_addr), 64'd0);
      checkOutput("async_wr_data", 64'(wr_data), 64'd0);
      checkOutput("async_rr_ptr", 64'(dut.rr_ptr), 64'd0);
      checkOutput("async_src_ready", 64'(src_ready), 64'd0);
      modelReset();
      src_valid = 4'b0000;
      @(negedge clk);
      rst_aH = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("lost_transfer_wr_en", 64'(wr_en), 64'd0);
      applyStimulus(4'b0101, 1'b0, g);
      checkOutput("post_reset_grant", 64'(g), 64'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #50000;
      $display("[TB] FAIL timeout: simulation did not finish within 50000 time units");
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The block SHALL have parameter ENTRY_WIDTH, default 32, meaning the width of each data word.
REQ-002 The block SHALL have parameter N_ENTRIES, default 32, meaning the register count; PTR_WIDTH SHALL be a localparam equal to $clog2(N_ENTRIES).
REQ-003 The block SHALL have parameter N_SRCS, default 4, meaning the number of competing writeback sources; legal range is 2 to 8.
REQ-004 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-005 rst_aH  input  1  asynchronous, active-high reset.
REQ-006 flush  input  1  discard this cycle's arbitration and clear arbiter state.
REQ-007 src_valid  input  [N_SRCS-1:0]  per-source write request.
REQ-008 src_addr  input  [N_SRCS-1:0][PTR_WIDTH-1:0]  per-source destination register.
REQ-009 src_data  input  [N_SRCS-1:0][ENTRY_WIDTH-1:0]  per-source write data.
REQ-010 src_ready  output  [N_SRCS-1:0]  per-source grant; a transfer occurs on a cycle when src_valid[i] and src_ready[i] are both 1.
REQ-011 wr_en  output  1  registered write enable to the register file write port.
REQ-012 wr_addr  output  PTR_WIDTH  registered write address.
REQ-013 wr_data  output  ENTRY_WIDTH  registered write data.

Function
REQ-014 src_ready SHALL be combinational from src_valid, rr_ptr and flush, and SHALL be one-hot or all-zero.
REQ-015 When flush=0, the block SHALL grant the valid source with the lowest index i >= rr_ptr; if there is none, it SHALL wrap and grant the lowest valid index < rr_ptr.
REQ-016 When no src_valid bit is set, or when flush=1, src_ready SHALL be all zero.
REQ-017 On a transfer from source g, on the next edge wr_addr SHALL load src_addr[g], wr_data SHALL load src_data[g], and wr_en SHALL load (src_addr[g] != 0).
REQ-018 The latency from the transfer cycle to the register-file write cycle SHALL be exactly 1 cycle; there SHALL be no backpressure from the write port.
REQ-019 A write to address 0 SHALL be consumed: src_ready is asserted, wr_en=0 on the following cycle, and the arbiter pointer advances normally.
REQ-020 On a cycle with no transfer, wr_en SHALL be 0 on the following cycle, and wr_addr and wr_data SHALL hold their previous values.
REQ-021 On a transfer from source g, rr_ptr SHALL load (g+1) mod N_SRCS; with no transfer and flush=0, rr_ptr SHALL hold.
REQ-022 When flush=1, the next-cycle wr_en SHALL be 0 and rr_ptr SHALL load 0, regardless of src_valid.
REQ-023 A source holding src_valid=1 continuously SHALL receive src_ready within N_SRCS cycles, provided flush=0.
REQ-024 src_addr and src_data SHALL be sampled only on the transfer cycle; sources must hold them stable until src_ready.
REQ-025 The block SHALL assert, outside reset, that src_ready is one-hot or zero and that src_ready implies src_valid on the same bit.

Reset
REQ-026 While rst_aH=1, wr_en, wr_addr, wr_data and rr_ptr SHALL be 0 asynchronously, and src_ready SHALL be all zero.
REQ-027 After rst_aH deasserts, the first grant SHALL follow REQ-015 with rr_ptr=0.
REQ-028 If reset asserts during a transfer cycle, that transfer SHALL be lost, and wr_en SHALL be 0 on the next cycle.

Verification (N_SRCS=4)
REQ-029 Reset, then src_valid=4'b1111 held for 4 cycles with addr_i=i+1 -> grants in order 0,1,2,3; wr_en=1 on cycles 1-4 with wr_addr 1,2,3,4.
REQ-030 rr_ptr=2 and src_valid=4'b0011 -> source 0 is granted, then rr_ptr=1; holding the valid -> source 1 is granted next.
REQ-031 Single source 1 with addr=0 and data=0xDEADBEEF -> src_ready[1]=1, next-cycle wr_en=0, and rr_ptr becomes 2.
REQ-032 src_valid=4'b1000 with flush=1 -> src_ready=0, next-cycle wr_en=0 and rr_ptr=0; after flush drops, source 3 is granted.
REQ-033 Source 2 holds valid for 20 cycles while the others toggle randomly -> source 2 is granted at least every 4 cycles, and the data matches on the next cycle.
REQ-034 Assert rst_aH mid-cycle after a grant -> wr_en, wr_addr, wr_data and rr_ptr drop to 0 immediately, without waiting for a clock edge.
